// File: rtl/wb_data_ram_slave.sv
// ---------------------------------------------------------------------------
// wb_data_ram_slave
//
// Wishbone-classic responder for the CPU data bus of the minimal SOPC. Serves
// read/write cycles from the core's data-side master out of an on-chip RAM of
// 2**ADDR_WIDTH 32-bit words. A configurable number of wait states is inserted
// before ack. Accesses outside the RAM or not word aligned end with err.
//
// Handshake: a request is present while wb_cyc_i & wb_stb_i are both high.
// The initiator must hold the request and its attributes until it sees
// wb_ack_o or wb_err_o (each a one-cycle pulse). Dropping the request during
// the wait phase abandons the access with no termination and no write.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   wb_cyc_i     bus cycle valid
//   wb_stb_i     strobe
//   wb_we_i      1 = write, 0 = read
//   wb_adr_i     byte address
//   wb_sel_i     byte lane enables (sel[3] -> dat[31:24] ... sel[0] -> dat[7:0])
//   wb_dat_i     write data
//   wb_dat_o     read data, zero whenever wb_ack_o is low
//   wb_ack_o     normal termination pulse
//   wb_err_o     error termination pulse
//   dbg_state_o  current FSM state (IDLE=0, WAIT=1, ACK=2, ERR=3)
// ---------------------------------------------------------------------------
module wb_data_ram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Counter preload when entering WAIT; only used when WAIT_STATES > 0.
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q,   cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q,   adr_d;
    logic                  we_q,    we_d;
    logic [3:0]            sel_q,   sel_d;
    logic [31:0]           dat_q,   dat_d;
    logic                  ack_q,   ack_d;
    logic                  err_q,   err_d;
    logic [31:0]           rdat_q,  rdat_d;

    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  bad_adr;
    logic [ADDR_WIDTH-1:0] in_word;
    logic                  mem_we;

    assign req     = wb_cyc_i & wb_stb_i;
    assign in_word = wb_adr_i[ADDR_WIDTH+1:2];
    // Any address bit above the RAM's byte range, or a non-word-aligned
    // address, is an error.
    assign bad_adr = ((wb_adr_i >> (ADDR_WIDTH + 2)) != 32'd0) || (wb_adr_i[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = 32'd0;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    adr_d = in_word;
                    we_d  = wb_we_i;
                    sel_d = wb_sel_i;
                    dat_d = wb_dat_i;
                    if (bad_adr) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        // Latched copies are not valid yet, so read with the
                        // live address and direction.
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        rdat_d  = wb_we_i ? 32'd0 : mem[in_word];
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    rdat_d  = we_q ? 32'd0 : mem[adr_q];
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK: begin
                // The write lands on the edge that ends the ACK cycle, and
                // only if the initiator is still presenting the request.
                mem_we  = req & we_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    // RAM contents survive reset; the write enable derives from state_q,
    // which reset forces to IDLE, so an aborted ACK never commits.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem[adr_q][8*i +: 8] <= dat_q[8*i +: 8];
                end
            end
        end
    end

    assign wb_dat_o    = rdat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// ---------------------------------------------------------------------------
// Testbench for wb_data_ram_slave. Four instances with WAIT_STATES = 0..3
// (instance k has k wait states) share the bus inputs; each has its own cyc.
// ---------------------------------------------------------------------------
module tb_wb_data_ram_slave;

    localparam int AW = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] dat_o [4];
    logic [1:0]  st    [4];

    wb_data_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o[0]),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]), .dbg_state_o(st[0]));
    wb_data_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o[1]),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]), .dbg_state_o(st[1]));
    wb_data_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[2]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o[2]),
        .wb_ack_o(ack[2]), .wb_err_o(err[2]), .dbg_state_o(st[2]));
    wb_data_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[3]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o[3]),
        .wb_ack_o(ack[3]), .wb_err_o(err[3]), .dbg_state_o(st[3]));

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // Expected responses: {instance[1:0], is_err, read data}
    logic [34:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [3:0]  prev_hit = 4'd0;
    logic [34:0] mon_e;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            check("ack_err_exclusive", 32'(ack[k] & err[k]), 32'd0);
            if (!ack[k]) check("dat_zero_without_ack", dat_o[k], 32'd0);
            if (ack[k] | err[k]) begin
                check("no_back_to_back", 32'(prev_hit[k]), 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_response: inst %0d ack=%b err=%b dat=%h, expected none",
                             k, ack[k], err[k], dat_o[k]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_inst", 32'(k), 32'(mon_e[34:33]));
                    check("resp_err",  32'(err[k]), 32'(mon_e[32]));
                    check("resp_dat",  dat_o[k], mon_e[31:0]);
                end
            end
        end
        prev_hit <= ack | err;
    end

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        cyc   = 4'd0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = 32'd0;
        sel   = 4'd0;
        dat_i = 32'd0;
    endtask

    // One complete access on instance k (which has k wait states). The
    // request is held through the ack/err cycle, then dropped.
    task automatic access(input int k, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_dat);
        int lat;
        bit hit;
        @(posedge clk); #1;
        cyc[k] = 1'b1;
        stb    = 1'b1;
        we     = w;
        adr    = a;
        sel    = s;
        dat_i  = d;
        exp_q.push_back({2'(k), e_err, e_dat});
        lat = 0;
        hit = 1'b0;
        while (!hit && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            hit = ack[k] | err[k];
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout: inst %0d adr %h got no response, expected one", k, a);
        end else begin
            check("latency", 32'(lat), e_err ? 32'd1 : 32'(1 + k));
        end
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic check_all_quiet(input string name);
        for (int k = 0; k < 4; k++) begin
            check({name, "_ack"}, 32'(ack[k]), 32'd0);
            check({name, "_err"}, 32'(err[k]), 32'd0);
            check({name, "_dat"}, dat_o[k], 32'd0);
        end
    endtask

    task automatic count_hits(input int k, input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (ack[k] | err[k]) hits++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          inst;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int hits;

        bus_idle();

        // Reset with random bus activity.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cyc   = 4'($urandom_range(0, 15));
            stb   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            adr   = 32'($urandom_range(0, 255)) << 2;
            sel   = 4'($urandom_range(0, 15));
            dat_i = $urandom();
            check_all_quiet("reset");
            for (int k = 0; k < 4; k++) check("reset_state", 32'(st[k]), 32'd0);
        end
        bus_idle();
        #1 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_all_quiet("post_reset_idle");
        end

        //           inst we    adr            sel    dat            err   exp_dat
        vecs.push_back('{1, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1, 1'b1, 32'h0000_0010, 4'h5, 32'h1122_3344, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b0, 32'hDE22_BE44});
        vecs.push_back('{1, 1'b0, 32'h0000_1000, 4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0000_0012, 4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b1, 32'h0000_0012, 4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b1, 32'h0000_1010, 4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDE22_BE44});
        vecs.push_back('{1, 1'b1, 32'h0000_0FFC, 4'hF, 32'hA5A5_0001, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         1'b0, 32'hA5A5_0001});
        vecs.push_back('{1, 1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDE22_BE44});
        vecs.push_back('{0, 1'b1, 32'h0000_0004, 4'hF, 32'h1234_5678, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0000_0004, 4'hF, 32'h0,         1'b0, 32'h1234_5678});
        vecs.push_back('{0, 1'b1, 32'h0000_0004, 4'hA, 32'hAABB_CCDD, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0000_0004, 4'h1, 32'h0,         1'b0, 32'hAA34_CC78});
        vecs.push_back('{0, 1'b0, 32'h8000_0000, 4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{3, 1'b1, 32'h0000_0020, 4'hF, 32'h0BAD_0BAD, 1'b0, 32'h0});
        vecs.push_back('{3, 1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 32'h0BAD_0BAD});
        vecs.push_back('{2, 1'b1, 32'h0000_0030, 4'hF, 32'h0102_0304, 1'b0, 32'h0});
        vecs.push_back('{2, 1'b0, 32'h0000_0030, 4'hF, 32'h0,         1'b0, 32'h0102_0304});

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].inst, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                   vecs[i].exp_err, vecs[i].exp_dat);
        end

        // Abort: WAIT_STATES=3 write dropped after two cycles.
        @(posedge clk); #1;
        cyc[3] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat_i = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1 bus_idle();
        count_hits(3, 8, hits);
        check("abort_no_response", 32'(hits), 32'd0);
        access(3, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'h0BAD_0BAD);

        // Async reset during WAIT (WAIT_STATES=2).
        @(posedge clk); #1;
        cyc[2] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h30; sel = 4'hF;
        @(posedge clk); #3;
        check("wait_state_before_rst", 32'(st[2]), 32'd1);
        rst = 1'b0;
        #1;
        check("wait_rst_state", 32'(st[2]), 32'd0);
        check_all_quiet("wait_rst");
        @(posedge clk); #1 bus_idle();
        @(posedge clk); #1 rst = 1'b1;
        count_hits(2, 5, hits);
        check("wait_rst_no_response", 32'(hits), 32'd0);
        access(2, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 32'h0102_0304);

        // Async reset during the ACK cycle of a write: ack drops at once and
        // the write is not committed.
        @(posedge clk); #1;
        cyc[2] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; sel = 4'hF; dat_i = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1 check("ack_before_rst", 32'(ack[2]), 32'd1);
        #1 rst = 1'b0;
        #1 check_all_quiet("ack_rst");
        @(posedge clk); #1 bus_idle();
        @(posedge clk); #1 rst = 1'b1;
        access(2, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 32'h0102_0304);

        // Throughput: WAIT_STATES=0 read held six cycles.
        repeat (3) exp_q.push_back({2'd0, 1'b0, 32'hAA34_CC78});
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check("throughput_ack", 32'(ack[0]), 32'(i % 2));
        end
        @(posedge clk); #1 bus_idle();

        repeat (4) @(posedge clk);
        #1 check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/wb_data_ram_slave.md
Name: wb_data_ram_slave

Overview:
- Wishbone-classic responder for the CPU data bus inside the minimal SOPC.
- Answers read/write cycles from the core's bus initiator (the data-side master) with an on-chip word RAM.
- Wait-state insertion is configurable; out-of-range or misaligned accesses get an error termination.
- Gives the SOPC a data-memory end of the bus protocol that the core drives.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words, byte range 0 .. 4*2**ADDR_WIDTH-1.
- WAIT_STATES, 1, extra cycles inserted before ack; legal range 0..7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_cyc_i  input  1  bus cycle valid.
- wb_stb_i  input  1  strobe; request = wb_cyc_i & wb_stb_i.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_adr_i  input  32  byte address.
- wb_sel_i  input  4  byte lane enables; sel[3]->dat[31:24] ... sel[0]->dat[7:0].
- wb_dat_i  input  32  write data.
- wb_dat_o  output  32  read data; 0 whenever wb_ack_o is low.
- wb_ack_o  output  1  normal termination, one-cycle pulse.
- wb_err_o  output  1  error termination, one-cycle pulse.

Behaviour:
- Reset (rst low, async): state IDLE, wait counter 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, latched request cleared. RAM contents are not cleared.
- Reset asserted mid-transaction aborts it: no write is committed and no ack/err is issued.
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE:
  - On request, latch adr, we, sel, dat.
  - Bad access (adr[31:ADDR_WIDTH+2] != 0, or adr[1:0] != 0) -> ERR.
  - Otherwise, WAIT_STATES == 0 -> ACK; else load counter = WAIT_STATES-1 and go to WAIT.
- WAIT:
  - Request dropped (cyc or stb low) -> IDLE, no ack, no write.
  - Counter == 0 -> ACK; else decrement.
- ACK:
  - wb_ack_o=1 for exactly one cycle.
  - Read: wb_dat_o = RAM[latched word addr], all 32 bits regardless of sel.
  - Write: the selected byte lanes of the latched data are committed on the rising edge that ends the ACK cycle, only if the request is still present during ACK. Unselected lanes are unchanged.
  - Next state is always IDLE.
- ERR: wb_err_o=1 for one cycle, wb_dat_o=0, no RAM access; next state IDLE.
- Latency: ack/err is high in cycle N+1+WAIT_STATES, where N is the cycle in which the request is first sampled in IDLE (err always N+1).
- Ack and err are never high in the same cycle and never high in two consecutive cycles. A request held continuously is serviced again after one IDLE cycle, so minimum spacing is 2+WAIT_STATES cycles.
- wb_we_i with wb_sel_i=0: a legal no-op write that still acks.
- Read-after-write to the same word returns the new data.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rst low 3 cycles with random bus inputs -> ack=0, err=0, dat_o=0. Release, then idle 5 cycles -> still 0.
- WAIT_STATES=1: write adr 0x10, dat 0xDEADBEEF, sel 0xF. Then read 0x10 -> ack 2 cycles after each request sample; read dat_o=0xDEADBEEF during ack only.
- Byte lanes: after the prior write, write 0x11223344 with sel 0x5 -> read 0x10 returns 0xDE22BE44.
- Error: read 0x0000_1000 (ADDR_WIDTH=10), and separately read 0x12 -> err pulse at N+1, ack never asserted, RAM unchanged.
- Abort: WAIT_STATES=3, start write to 0x20 with 0xCAFEF00D, drop stb after 2 cycles -> no ack, no err; read 0x20 returns the prior value.
- Async reset mid-op: WAIT_STATES=2, assert rst during WAIT -> outputs 0 immediately (before the next edge). After release, a new read completes normally.
- Throughput: WAIT_STATES=0, hold a read request 6 cycles -> ack pattern 0,1,0,1,0,1.
